// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// the opcode-to-strobe decoder.
package alu_pkg;

    localparam logic [2:0] OP_CMP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        LDA,
        GAPA,
        LDB,
        GAPB,
        EXEC,
        RESP
    } seqState_t;

    // Bit index equals opcode: [0]=Cmp [1]=Add [2]=Sub [3]=Div [4]=Mul.
    // Illegal opcodes decode to all-zero.
    function automatic logic [4:0] op_to_onehot(input logic [2:0] op);
        op_to_onehot = 5'b00000;
        if (op <= OP_MUL) op_to_onehot = 5'b00001 << op;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU datapath: loads both operands with
// separated single-cycle strobes, fires one op strobe, captures Y and responds.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic [3:0]       Datain,
    output logic             ldA,
    output logic             ldB,
    output logic             aCmp,
    output logic             aAdd,
    output logic             aSub,
    output logic             aDiv,
    output logic             aMul,
    input  logic [7:0]       Y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data,
    output logic [2:0]       res_op,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    seqState_t  state;
    logic [2:0] opReg;
    logic [3:0] bReg;
    logic [3:0] settleCnt;
    logic [4:0] strobeReg;

    logic cmdBad;
    assign cmdBad = (cmd_op > OP_MUL) || (cmd_op == OP_DIV && cmd_b == 4'd0);

    // Gated by rst_n so the channel reads not-ready only while reset is held.
    assign cmd_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);
    assign {aMul, aDiv, aSub, aAdd, aCmp} = strobeReg;

    // NOTE: every register here is assigned with <= so all updates in this
    // block see pre-edge values; blocking = would chain updates within a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            opReg      <= 3'd0;
            bReg       <= 4'd0;
            settleCnt  <= 4'd0;
            strobeReg  <= 5'b00000;
            Datain     <= 4'd0;
            ldA        <= 1'b0;
            ldB        <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= 8'd0;
            res_op     <= 3'd0;
            res_err    <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        opReg <= cmd_op;
                        bReg  <= cmd_b;
                        if (cmdBad) begin
                            // Error path never touches the datapath pins.
                            state    <= RESP;
                            res_err  <= 1'b1;
                            res_data <= 8'd0;
                            res_op   <= cmd_op;
                        end else begin
                            state  <= LDA;
                            Datain <= cmd_a;
                            ldA    <= 1'b1;
                        end
                    end
                end
                LDA: begin
                    ldA   <= 1'b0;
                    state <= GAPA;
                end
                GAPA: begin
                    Datain <= bReg;
                    ldB    <= 1'b1;
                    state  <= LDB;
                end
                LDB: begin
                    ldB   <= 1'b0;
                    state <= GAPB;
                end
                GAPB: begin
                    strobeReg <= op_to_onehot(opReg);
                    settleCnt <= SETTLE_LOAD;
                    state     <= EXEC;
                end
                EXEC: begin
                    if (settleCnt == 4'd0) begin
                        strobeReg <= 5'b00000;
                        Datain    <= 4'd0;
                        res_data  <= Y;
                        res_op    <= opReg;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        settleCnt <= settleCnt - 4'd1;
                    end
                end
                RESP: begin
                    // An error response arrives with res_valid low and raises it one edge later.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                    end else if (res_ready) begin
                        res_valid  <= 1'b0;
                        done_count <= done_count + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator for the 4-bit ALU datapath. It accepts one operation command (opcode plus two 4-bit operands) over a valid/ready handshake. It then drives the datapath load pins (Datain, ldA, ldB) and the one-hot operation strobes (aCmp/aAdd/aSub/aDiv/aMul), waits a fixed settle time, captures the 8-bit result Y and returns it over a valid/ready response channel. It sits between the system command source and the ALU datapath.

Parameters:
SETTLE_CYCLES, 2, cycles the op strobe is held before Y is captured (legal range 1..15).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  0=CMP 1=ADD 2=SUB 3=DIV 4=MUL; 5..7 illegal
cmd_a  input  4  operand A
cmd_b  input  4  operand B
Datain  output  4  nibble to datapath
ldA  output  1  datapath load-A strobe
ldB  output  1  datapath load-B strobe
aCmp, aAdd, aSub, aDiv, aMul  output  1 each  one-hot op strobes
Y  input  8  datapath result
res_valid  output  1  response present
res_ready  input  1  consumer accepts response
res_data  output  8  captured result (0 on error)
res_op  output  3  opcode echoed
res_err  output  1  illegal opcode or divide-by-zero
busy  output  1  state != IDLE
done_count  output  CNT_W  responses delivered

Behaviour:
- Reset: all outputs 0; state IDLE; cmd_ready is 0 only while rst_n is low.
- Registered FSM: IDLE, LDA, GAPA, LDB, GAPB, EXEC, RESP.
- IDLE: cmd_ready=1. A handshake on edge E0 latches op, a and b.
  - Legal op with !(op==DIV && b==0): next state LDA.
  - Otherwise: next state RESP with res_err=1 and res_data=0. No datapath pin toggles. res_valid is high after E1.
- LDA (1 cycle): Datain=a, ldA=1.
- GAPA (1 cycle): ldA=0, Datain held at a. The datapath is level-sensitive, so every load strobe is a single-cycle pulse separated by a low cycle.
- LDB (1 cycle): Datain=b, ldB=1.
- GAPB (1 cycle): ldB=0, Datain held at b.
- EXEC: exactly one op strobe high, selected by op, for SETTLE_CYCLES cycles via a down-counter. On the final EXEC edge, Y is captured into res_data and the strobe drops.
- Legal-op latency: res_valid rises after edge E(4+SETTLE_CYCLES), i.e. E6 by default.
- RESP: res_valid=1. res_data, res_op and res_err stay stable until res_ready. On the accepting edge: res_valid drops, done_count increments (wraps at 2^CNT_W-1 to 0), next state IDLE.
- cmd_ready is low outside IDLE, which gives at least one bubble cycle between commands.
- No more than one of ldA/ldB/op-strobes is ever high in the same cycle. Datain is 0 in IDLE and RESP.
- Reset mid-operation: everything returns to reset values immediately and the in-flight command is dropped with no response. Datapath operand registers are not reset; the next command reloads both operands fully.
- cmd_valid may drop without a handshake; no latch occurs.
- res_ready asserted outside RESP is ignored.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_CMP..OP_MUL.
  - FSM state enum.
  - Function op_to_onehot(op) -> 5-bit strobe vector (bit order Cmp, Add, Sub, Div, Mul).
- Single module. The settle counter and done_count stay inline; no sub-module is warranted.

Test Plan:
- ADD, a=3, b=5, Y model = a+b, res_ready=1 -> ldA pulse with Datain=3, then ldB pulse with Datain=5, aAdd high 2 cycles; res_valid after 6 edges; res_data=0x08; res_err=0; done_count=1.
- MUL, a=15, b=15, res_ready held low 4 cycles -> res_data=0xE1 stays stable while res_valid is high; cmd_ready=0 throughout; accepted on res_ready; done_count increments once.
- DIV, b=0 -> no ldA/ldB/aDiv activity; res_valid after 1 edge with res_err=1, res_data=0, res_op=3.
- cmd_op=6 -> error response as above; then a SUB a=9, b=4 issued immediately after -> res_data=0x05, res_err=0.
- rst_n low during EXEC of CMP -> all strobes and res_valid go 0 asynchronously; after release, an ADD a=1, b=1 completes with res_data=0x02 and done_count=1.
- Sweep all 5 ops with SETTLE_CYCLES=1 and 15 -> latency equals 4+SETTLE_CYCLES edges; assertion that strobes are one-hot or zero every cycle.
